// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low pattern table, blank code, capture FSM states.
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_e;

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] nib;
  } seg_dec_t;
endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the display encoder: segment pattern -> nibble plus legality.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);
  always_comb begin
    dec_o          = '0;
    dec_o.is_blank = (seg_i == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_TABLE[i]) begin
        dec_o.legal = 1'b1;
        dec_o.nib   = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// Captures the multiplexed anode/segment bus and rebuilds the displayed NDIG-digit word.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int STABLE_CNT  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NDIG-1:0]        an,
  input  logic [6:0]             seg,
  output logic [4*NDIG-1:0]      value,
  output logic                   value_valid,
  output logic [NDIG-1:0]        blank,
  output logic [NDIG-1:0]        err,
  input  logic                   err_clr
);
  localparam int         W   = NDIG + 7;
  localparam logic [7:0] STB = 8'(STABLE_CNT);

  logic [W-1:0] raw_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign raw_s = {an, seg};
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    // Reset to the idle bus (all anodes off, all segments off).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else begin
        sync_q[0] <= {an, seg};
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign raw_s = sync_q[SYNC_STAGES-1];
  end

  logic [NDIG-1:0] an_n;
  logic [6:0]      seg_s;
  logic            onehot, same, acc, ill;
  seg_dec_t        dec;

  assign an_n   = ~raw_s[W-1:7];
  assign seg_s  = raw_s[6:0];
  assign onehot = (an_n != '0) && ((an_n & (an_n - 1'b1)) == '0);

  seg7_to_hex u_dec (.seg_i(seg_s), .dec_o(dec));

  logic [W-1:0]           smp_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [NDIG-1:0][3:0]   nib_q, nib_d, value_q, value_d;
  logic [NDIG-1:0]        blank_q, blank_d, err_q, err_d, seen_q, seen_d;
  logic                   ferr_q, ferr_d;
  state_e                 state_q, state_d;

  assign same = (raw_s == smp_q);
  // Accept exactly once per dwell: on the cycle the count first lands on STB.
  assign acc  = onehot && (cnt_d == STB) && !(same && cnt_q == STB);
  assign ill  = acc && !dec.legal && !dec.is_blank;

  always_comb begin
    cnt_d = cnt_q;
    if (!onehot)          cnt_d = '0;
    else if (!same)       cnt_d = 8'd1;
    else if (cnt_q < STB) cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    err_d   = err_q & ~{NDIG{err_clr}};
    if (acc) begin
      for (int i = 0; i < NDIG; i++) begin
        if (an_n[i]) begin
          if (dec.legal) begin
            nib_d[i]   = dec.nib;
            blank_d[i] = 1'b0;
          end else if (dec.is_blank) begin
            blank_d[i] = 1'b1;
          end else begin
            err_d[i]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    ferr_d  = ferr_q;
    value_d = value_q;
    unique case (state_q)
      SYNC: begin
        if (acc && an_n[0]) begin
          state_d = COLLECT;
          seen_d  = NDIG'(1);
          ferr_d  = ill;
        end
      end
      COLLECT: begin
        if (&seen_q) begin
          seen_d = '0;
          ferr_d = 1'b0;
          if (ferr_q) state_d = SYNC;
          else begin
            state_d = PUBLISH;
            value_d = nib_q;
          end
        end else if (acc) begin
          seen_d = seen_q | an_n;
          ferr_d = ferr_q | ill;
        end
      end
      PUBLISH: begin
        state_d = COLLECT;
        seen_d  = acc ? an_n : '0;
        ferr_d  = ill;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q   <= '1;
      cnt_q   <= '0;
      nib_q   <= '0;
      blank_q <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      ferr_q  <= 1'b0;
      value_q <= '0;
      state_q <= SYNC;
    end else begin
      smp_q   <= raw_s;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      ferr_q  <= ferr_d;
      value_q <= value_d;
      state_q <= state_d;
    end
  end

  assign value       = value_q;
  assign value_valid = (state_q == PUBLISH);
  assign blank       = blank_q;
  assign err         = err_q;
endmodule
